pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//   Owns the architectural PC register and sequences instruction fetch in the pipelined core.
//   Drives the instruction-ROM request handshake and accepts hazard-unit stalls.
//   Accepts EX-stage redirects, whose target is produced by the next-PC calculator, and flushes the IF/ID slot.
//   Sits between the PC calculator (EX), the hazard unit and the instruction memory.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded by reset; the first fetch address
// PORTS
//   cpu_clk      in   1   core clock; all state changes on the rising edge
//   cpu_rst      in   1   synchronous reset, active-high
//   stall        in   1   hazard unit: hold PC and the IF/ID outputs this cycle
//   redir_valid  in   1   EX resolved a taken branch or jump this cycle
//   redir_pc     in   32  redirect target (npc from the PC calculator)
//   irom_req     out  1   fetch request to instruction memory
//   irom_addr    out  32  fetch address; must stay stable while irom_req && !irom_ready
//   irom_ready   in   1   fetch completes this cycle; irom_inst is valid
//   irom_inst    in   32  fetched instruction word
//   if_valid     out  1   if_pc / if_inst hold a live instruction for ID
//   if_pc        out  32  PC of the instruction presented to ID
//   if_inst      out  32  instruction presented to ID
//   flush        out  1   combinational copy of redir_valid; kills the IF/ID slot this cycle
// BEHAVIOUR
// Reset
//   - cpu_rst=1 gives pc=RESET_PC and state=BOOT.
//   - It also clears if_valid=0, if_pc=0, if_inst=0, the skid buffer, and irom_req=0.
//   - Reset mid-transaction abandons the outstanding request; the response is ignored.
// States
//   - BOOT: one idle cycle, then FETCH.
//   - FETCH: irom_req=1, irom_addr=pc.
//   - HOLD: a word is captured in the skid buffer while stalled; irom_req=0.
//   - DROP: a stale request is still outstanding after a redirect.
// Normal fetch (FETCH)
//   - Fetch completes and stall=0: on the next edge, if_valid=1, if_pc=pc, if_inst=irom_inst.
//   - In the same edge, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//   - Back-to-back completions therefore give one instruction per cycle.
//   - No completion and stall=0: if_valid<=0 (bubble); pc is unchanged; the request is held.
// Stall
//   - While stall=1, pc, if_valid, if_pc and if_inst all hold.
//   - Completion while stall=1: store {pc, irom_inst} in the skid buffer, pc<=pc+4, go to HOLD.
//   - HOLD with stall=0: move the buffer to the if_* outputs (if_valid=1), return to FETCH.
// Redirect (highest priority; beats stall and completion in the same cycle)
//   - redir_valid=1 asserts flush=1 in the same cycle.
//   - On the next edge: pc<=redir_pc with bits [1:0] forced to 0; if_valid<=0; skid buffer cleared.
//   - Request outstanding with irom_ready=0: go to DROP.
//   - DROP keeps irom_req=1 with the old address until irom_ready, discards that word, then goes to FETCH.
//   - Redirect arriving in FETCH with irom_ready=1: the word is discarded, next state is FETCH.
//   - Redirect arriving in HOLD: buffer discarded, next state is FETCH.
//   - Redirect arriving in DROP: pc updated again; state stays DROP.
// Latency and arithmetic
//   - Redirect to first request at the new PC: 1 cycle, plus any remaining DROP wait.
//   - All PC arithmetic is 32-bit unsigned; the core raises no exceptions.
// TESTING
//   - Reset release, irom_ready tied 1.
//     -> irom_addr 0,4,8,C on consecutive cycles.
//     -> if_pc trails irom_addr by one cycle; if_valid=1 from cycle 2.
//   - irom_ready low 3 cycles on addr 0x8.
//     -> irom_addr holds 0x8 and if_valid=0 during the wait.
//     -> 0x8 is delivered on the cycle after ready.
//   - stall=1 for 2 cycles while the fetch of 0x10 completes.
//     -> if_* frozen on 0x0C; state goes to HOLD.
//     -> 0x10 is presented the cycle stall drops, and the next request is 0x14.
//   - redir_valid=1, redir_pc=0x100 with a fetch of 0x20 outstanding (ready=0).
//     -> flush=1 that cycle.
//     -> 0x20 response discarded; next request is 0x100; no if_valid for 0x20.
//   - Same cycle: redir_valid=1 (0x203), stall=1, irom_ready=1.
//     -> Redirect wins; the next request is 0x200; if_valid=0.
//   - Assert cpu_rst during DROP.
//     -> irom_req=0 next cycle, pc=RESET_PC.
//     -> Fetch restarts at RESET_PC after BOOT.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-ROM handshake and the IF/ID slot.
interface pc_fetch_ctrl_if;
   logic        stall;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        irom_req;
   logic [31:0] irom_addr;
   logic        irom_ready;
   logic [31:0] irom_inst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        flush;

   modport master (
      input  stall, redir_valid, redir_pc, irom_ready, irom_inst,
      output irom_req, irom_addr, if_valid, if_pc, if_inst, flush
   );

   modport slave (
      output stall, redir_valid, redir_pc, irom_ready, irom_inst,
      input  irom_req, irom_addr, if_valid, if_pc, if_inst, flush
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: drives the instruction-ROM request, absorbs stalls
// through a one-entry skid buffer and discards stale responses after a redirect.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic              cpu_clk,
   input logic              cpu_rst,
   pc_fetch_ctrl_if.master  fetch
);

   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_inst_q, skid_inst_d;

   logic [31:0] redir_tgt;
   logic [31:0] pc_inc;

   assign redir_tgt = {fetch.redir_pc[31:2], 2'b00};
   assign pc_inc    = pc_q + 32'd4;

   assign fetch.flush     = fetch.redir_valid;
   assign fetch.irom_req  = (state_q == FETCH) || (state_q == DROP);
   // DROP keeps presenting the abandoned address while pc already holds the new target
   assign fetch.irom_addr = (state_q == DROP) ? drop_addr_q : pc_q;
   assign fetch.if_valid  = if_valid_q;
   assign fetch.if_pc     = if_pc_q;
   assign fetch.if_inst   = if_inst_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;

      if (fetch.redir_valid) begin
         pc_d        = redir_tgt;
         if_valid_d  = 1'b0;
         skid_pc_d   = '0;
         skid_inst_d = '0;
         unique case (state_q)
            FETCH: begin
               state_d     = fetch.irom_ready ? FETCH : DROP;
               drop_addr_d = pc_q;
            end
            DROP:    state_d = fetch.irom_ready ? FETCH : DROP;
            default: state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (fetch.irom_ready) begin
                  pc_d = pc_inc;
                  if (fetch.stall) begin
                     skid_pc_d   = pc_q;
                     skid_inst_d = fetch.irom_inst;
                     state_d     = HOLD;
                  end else begin
                     if_valid_d = 1'b1;
                     if_pc_d    = pc_q;
                     if_inst_d  = fetch.irom_inst;
                  end
               end else if (!fetch.stall) begin
                  if_valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!fetch.stall) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = skid_pc_q;
                  if_inst_d  = skid_inst_q;
                  state_d    = FETCH;
               end
            end
            DROP: begin
               if (fetch.irom_ready) state_d = FETCH;
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         if_valid_q  <= 1'b0;
         if_pc_q     <= '0;
         if_inst_q   <= '0;
         skid_pc_q   <= '0;
         skid_inst_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
      end
   end

endmodule
